exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  MEM-stage exception arbiter and driver of the CP0 exception-commit interface.
//  - Collects per-instruction exception flags and the registered interrupt request.
//  - Picks one cause by priority and drives excepttype/EPC-source/delay-slot/bad-address to CP0.
//  - Issues a one-cycle pipeline flush with the redirect PC (exception vector or EPC for eret).
//  - Holds a detected exception across longest_stall so CP0 commits it exactly once.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  redirect PC for all exceptions and interrupts
//  DW          32             data/address width; must equal `RegBus width
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high (`RstEnable)
//  longest_stall  in   1   global stall; CP0 does not update while high
//  mem_valid_i    in   1   MEM slot holds a real instruction (not a bubble)
//  mem_pc_i       in   DW  PC of MEM instruction
//  mem_dslot_i    in   1   MEM instruction is in a delay slot
//  mem_flags_i    in   7   {eret,trap,ov,brk,sys,ri,fetch_adel}
//  mem_ld_adel_i  in   1   misaligned load
//  mem_st_ades_i  in   1   misaligned store
//  mem_daddr_i    in   DW  load/store effective address
//  cp0_status_i   in   DW  CP0 Status
//  cp0_cause_i    in   DW  CP0 Cause
//  cp0_epc_i      in   DW  CP0 EPC
//  wb_cp0_we_i    in   1   mtc0 in WB (bypass source)
//  wb_cp0_waddr_i in   5   mtc0 target register
//  wb_cp0_data_i  in   DW  mtc0 data
//  excepttype_o   out  DW  cause code to CP0; 0 = none
//  exc_pc_o       out  DW  current_inst_addr to CP0
//  exc_dslot_o    out  1   is_in_delayslot to CP0
//  bad_addr_o     out  DW  bad_addr to CP0
//  flush_o        out  1   flush IF..MEM this cycle
//  new_pc_o       out  DW  redirect target, valid when flush_o=1
// BEHAVIOUR
//  Bypass
//  - status/cause/epc effective = wb value when wb_cp0_we_i and waddr matches (`CP0_REG_*); else CP0 value.
//  - cause bypass touches only bits 9:8, 23, 22.
//  Interrupt
//  - int_req (register) <= Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), every non-stalled cycle.
//  - int_req holds its value while longest_stall is high.
//  Priority (high->low), codes
//  - int_req 0x1 > fetch_adel 0x4 (bad=pc) > ri 0xa > sys 0x8 > brk 0x9 > ov 0xc > trap 0xd
//    > ld_adel 0x4 (bad=daddr) > st_ades 0x5 (bad=daddr) > eret 0xe.
//  - Every cause, int_req included, requires mem_valid_i=1.
//  - bad_addr_o = 0 when the cause has no bad address.
//  FSM states: IDLE, HOLD, BLANK
//  - IDLE, no exc: all outputs 0.
//  - IDLE, exc, ~longest_stall: outputs driven combinationally from live inputs; flush_o=1; -> BLANK.
//  - IDLE, exc, longest_stall: latch code/pc/dslot/bad/new_pc into hold regs; outputs 0; -> HOLD.
//  - HOLD, longest_stall: outputs 0; stay.
//  - HOLD, ~longest_stall: drive hold regs and flush_o=1 for 1 cycle; -> BLANK.
//    Live inputs are ignored in HOLD.
//  - BLANK: outputs 0; new exceptions suppressed (the slot is a flushed bubble).
//    Stay while longest_stall, else -> IDLE.
//  new_pc
//  - eret: effective EPC, sampled at detection.
//  - all other causes: EXC_VECTOR.
//  Invariants
//  - flush_o is high iff excepttype_o != 0.
//  - At most one commit per instruction.
//  - Latency 0 cycles unstalled; commit on the first cycle after the stall drops.
//  Reset
//  - state=IDLE; int_req=0; hold regs=0; all outputs 0.
//  - Reset mid-HOLD discards the pending exception.
// STRUCTURE
//  - Shared defines.vh gains: `EXC_INT 1, `EXC_ADEL 4, `EXC_ADES 5, `EXC_SYS 8, `EXC_BP 9,
//    `EXC_RI 'ha, `EXC_OV 'hc, `EXC_TR 'hd, `EXC_ERET 'he, `EXC_NONE 0.
//    These are the codes CP0 decodes.
//  - One sub-module: exc_prio_enc (combinational priority encoder -> code + bad_addr select).
//  - FSM, bypass and hold regs stay in exception_ctrl.
// TESTING
//  1. sys at pc=0xBFC0_0100, dslot=0, no stall
//     -> same cycle: excepttype=0x8, exc_pc=0xBFC0_0100, flush=1, new_pc=0xBFC0_0380.
//     Next cycle all outputs 0 (BLANK).
//  2. Load AdEL, daddr=0x8000_0002, with ov also set -> excepttype=0xc, bad_addr=0 (ov wins).
//     Repeat with ld_adel only -> 0x4, bad_addr=0x8000_0002.
//  3. Status=0x0000_0401, Cause[10]=1, valid instr in MEM
//     -> next cycle excepttype=0x1.
//     Status.EXL=1 -> no interrupt.
//  4. eret with wb mtc0 EPC=0x1234_5678 same cycle
//     -> excepttype=0xe, new_pc=0x1234_5678 (bypass wins over cp0_epc_i).
//  5. brk while longest_stall=1 for 3 cycles
//     -> outputs 0 for 3 cycles; then exactly one cycle excepttype=0x9, flush=1.
//     Reset asserted during HOLD -> no commit ever appears.
//  6. fetch_adel, pc=0xBFC0_0101, dslot=1
//     -> excepttype=0x4, bad_addr=0xBFC0_0101, exc_dslot=1.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Exception controller shared types and constants.
// Cause codes decoded by CP0, CP0 register numbers, FSM states.
package exception_ctrl_pkg;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int FLG_FADEL = 0;
  localparam int FLG_RI    = 1;
  localparam int FLG_SYS   = 2;
  localparam int FLG_BRK   = 3;
  localparam int FLG_OV    = 4;
  localparam int FLG_TRAP  = 5;
  localparam int FLG_ERET  = 6;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_HOLD,
    EXC_BLANK
  } exc_state_e;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Priority encoder: picks one exception cause and its bad address.
// Ports: int_req, flags, ld_adel, st_ades, pc, daddr -> code, bad_addr, is_eret.
module exc_prio_enc
  import exception_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          int_req,
  input  logic [6:0]    flags,
  input  logic          ld_adel,
  input  logic          st_ades,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] daddr,
  output logic [4:0]    code,
  output logic [DW-1:0] bad_addr,
  output logic          is_eret
);

  always_comb begin
    code     = EXC_NONE;
    bad_addr = '0;
    is_eret  = 1'b0;
    if (int_req) begin
      code = EXC_INT;
    end else if (flags[FLG_FADEL]) begin
      code     = EXC_ADEL;
      bad_addr = pc;
    end else if (flags[FLG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLG_SYS]) begin
      code = EXC_SYS;
    end else if (flags[FLG_BRK]) begin
      code = EXC_BP;
    end else if (flags[FLG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLG_TRAP]) begin
      code = EXC_TR;
    end else if (ld_adel) begin
      code     = EXC_ADEL;
      bad_addr = daddr;
    end else if (st_ades) begin
      code     = EXC_ADES;
      bad_addr = daddr;
    end else if (flags[FLG_ERET]) begin
      code    = EXC_ERET;
      is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter driving the CP0 commit interface and flush.
// Ports: MEM slot info, CP0 regs + WB mtc0 bypass in; CP0 commit, flush, new_pc out.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int            DW         = 32,
  parameter logic [DW-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          longest_stall,
  input  logic          mem_valid_i,
  input  logic [DW-1:0] mem_pc_i,
  input  logic          mem_dslot_i,
  input  logic [6:0]    mem_flags_i,
  input  logic          mem_ld_adel_i,
  input  logic          mem_st_ades_i,
  input  logic [DW-1:0] mem_daddr_i,
  input  logic [DW-1:0] cp0_status_i,
  input  logic [DW-1:0] cp0_cause_i,
  input  logic [DW-1:0] cp0_epc_i,
  input  logic          wb_cp0_we_i,
  input  logic [4:0]    wb_cp0_waddr_i,
  input  logic [DW-1:0] wb_cp0_data_i,
  output logic [DW-1:0] excepttype_o,
  output logic [DW-1:0] exc_pc_o,
  output logic          exc_dslot_o,
  output logic [DW-1:0] bad_addr_o,
  output logic          flush_o,
  output logic [DW-1:0] new_pc_o
);

  exc_state_e    state, state_n;
  logic [DW-1:0] status_eff, cause_eff, epc_eff;
  logic          int_req, int_req_d;
  logic [4:0]    enc_code;
  logic [DW-1:0] enc_bad;
  logic          enc_eret;
  logic          exc;
  logic [DW-1:0] live_code, live_npc;
  logic          hold_we, drive_live, drive_hold;
  logic [DW-1:0] hold_code, hold_pc, hold_bad, hold_npc;
  logic          hold_dslot;
  logic          unused_bits;

  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_REG_STATUS)
        status_eff = wb_cp0_data_i;
      if (wb_cp0_waddr_i == CP0_REG_EPC)
        epc_eff = wb_cp0_data_i;
      // Only the software-writable Cause fields
      if (wb_cp0_waddr_i == CP0_REG_CAUSE) begin
        cause_eff[9:8] = wb_cp0_data_i[9:8];
        cause_eff[23]  = wb_cp0_data_i[23];
        cause_eff[22]  = wb_cp0_data_i[22];
      end
    end
  end

  assign int_req_d = status_eff[0] & ~status_eff[1]
                   & (|(cause_eff[15:8] & status_eff[15:8]));

  assign unused_bits = ^{status_eff, cause_eff};

  exc_prio_enc #(.DW(DW)) u_enc (
    .int_req  (int_req),
    .flags    (mem_flags_i),
    .ld_adel  (mem_ld_adel_i),
    .st_ades  (mem_st_ades_i),
    .pc       (mem_pc_i),
    .daddr    (mem_daddr_i),
    .code     (enc_code),
    .bad_addr (enc_bad),
    .is_eret  (enc_eret)
  );

  assign exc       = mem_valid_i & (enc_code != EXC_NONE);
  assign live_code = {{(DW-5){1'b0}}, enc_code};
  assign live_npc  = enc_eret ? epc_eff : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EXC_IDLE;
      int_req    <= 1'b0;
      hold_code  <= '0;
      hold_pc    <= '0;
      hold_dslot <= 1'b0;
      hold_bad   <= '0;
      hold_npc   <= '0;
    end else begin
      state <= state_n;
      if (!longest_stall)
        int_req <= int_req_d;
      if (hold_we) begin
        hold_code  <= live_code;
        hold_pc    <= mem_pc_i;
        hold_dslot <= mem_dslot_i;
        hold_bad   <= enc_bad;
        hold_npc   <= live_npc;
      end
    end
  end

  always_comb begin
    state_n    = state;
    hold_we    = 1'b0;
    drive_live = 1'b0;
    drive_hold = 1'b0;
    unique case (state)
      EXC_IDLE: begin
        if (exc) begin
          if (longest_stall) begin
            hold_we = 1'b1;
            state_n = EXC_HOLD;
          end else begin
            drive_live = 1'b1;
            state_n    = EXC_BLANK;
          end
        end
      end
      EXC_HOLD: begin
        if (!longest_stall) begin
          drive_hold = 1'b1;
          state_n    = EXC_BLANK;
        end
      end
      EXC_BLANK: begin
        if (!longest_stall)
          state_n = EXC_IDLE;
      end
      default: state_n = EXC_IDLE;
    endcase
  end

  always_comb begin
    excepttype_o = '0;
    exc_pc_o     = '0;
    exc_dslot_o  = 1'b0;
    bad_addr_o   = '0;
    flush_o      = 1'b0;
    new_pc_o     = '0;
    if (!rst) begin
      if (drive_live) begin
        excepttype_o = live_code;
        exc_pc_o     = mem_pc_i;
        exc_dslot_o  = mem_dslot_i;
        bad_addr_o   = enc_bad;
        flush_o      = 1'b1;
        new_pc_o     = live_npc;
      end else if (drive_hold) begin
        excepttype_o = hold_code;
        exc_pc_o     = hold_pc;
        exc_dslot_o  = hold_dslot;
        bad_addr_o   = hold_bad;
        flush_o      = 1'b1;
        new_pc_o     = hold_npc;
      end
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl.
// Output bundle: {excepttype, exc_pc, dslot, bad_addr, flush, new_pc}.
module tb_exception_ctrl;

  localparam logic [31:0]  VEC  = 32'hBFC0_0380;
  localparam logic [129:0] ZERO = '0;

  logic        clk, rst, longest_stall;
  logic        mem_valid, mem_dslot, ld_adel, st_ades;
  logic [31:0] mem_pc, daddr, status, cause, epc;
  logic [6:0]  flags;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic [31:0] excepttype, exc_pc, bad_addr, new_pc;
  logic        exc_dslot, flush;

  logic [129:0] obs, exp;
  int unsigned  total, bad;

  assign obs = {excepttype, exc_pc, exc_dslot, bad_addr, flush, new_pc};

  exception_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .longest_stall  (longest_stall),
    .mem_valid_i    (mem_valid),
    .mem_pc_i       (mem_pc),
    .mem_dslot_i    (mem_dslot),
    .mem_flags_i    (flags),
    .mem_ld_adel_i  (ld_adel),
    .mem_st_ades_i  (st_ades),
    .mem_daddr_i    (daddr),
    .cp0_status_i   (status),
    .cp0_cause_i    (cause),
    .cp0_epc_i      (epc),
    .wb_cp0_we_i    (wb_we),
    .wb_cp0_waddr_i (wb_waddr),
    .wb_cp0_data_i  (wb_data),
    .excepttype_o   (excepttype),
    .exc_pc_o       (exc_pc),
    .exc_dslot_o    (exc_dslot),
    .bad_addr_o     (bad_addr),
    .flush_o        (flush),
    .new_pc_o       (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [129:0] o(
    input logic [31:0] c, input logic [31:0] p, input logic d,
    input logic [31:0] b, input logic f, input logic [31:0] n);
    return {c, p, d, b, f, n};
  endfunction

  task automatic clr();
    longest_stall = 1'b0;
    mem_valid = 1'b0; mem_dslot = 1'b0;
    mem_pc = '0; daddr = '0; flags = '0;
    ld_adel = 1'b0; st_ades = 1'b0;
    status = '0; cause = '0; epc = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    step(); step();
    mem_valid = 1'b1; flags = 7'b0000100;
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset got=%h exp=%h", obs, exp);
    end
    clr(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_sys();
    mem_valid = 1'b1; mem_pc = 32'hBFC0_0100; flags = 7'b0000100;
    #1;
    exp = o(32'h8, 32'hBFC0_0100, 1'b0, 32'h0, 1'b1, VEC); total++;
    if (obs !== exp) begin
      bad++; $display("FAIL sys_commit got=%h exp=%h", obs, exp);
    end
    step();
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL sys_blank got=%h exp=%h", obs, exp);
    end
    clr(); step();
  endtask

  task automatic test_ld_adel();
    mem_valid = 1'b1; mem_pc = 32'h8000_1000;
    daddr = 32'h8000_0002; ld_adel = 1'b1; flags = 7'b0010000;
    #1;
    exp = o(32'hc, 32'h8000_1000, 1'b0, 32'h0, 1'b1, VEC); total++;
    if (obs !== exp) begin
      bad++; $display("FAIL ov_over_adel got=%h exp=%h", obs, exp);
    end
    step(); clr();
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL ov_blank got=%h exp=%h", obs, exp);
    end
    step();
    mem_valid = 1'b1; mem_pc = 32'h8000_1004;
    daddr = 32'h8000_0002; ld_adel = 1'b1;
    #1;
    exp = o(32'h4, 32'h8000_1004, 1'b0, 32'h8000_0002, 1'b1, VEC);
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL ld_adel got=%h exp=%h", obs, exp);
    end
    step(); clr(); step();
    mem_valid = 1'b1; mem_pc = 32'h8000_1008;
    daddr = 32'h8000_0003; st_ades = 1'b1; flags = 7'b1000000;
    #1;
    exp = o(32'h5, 32'h8000_1008, 1'b0, 32'h8000_0003, 1'b1, VEC);
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL st_ades got=%h exp=%h", obs, exp);
    end
    step(); clr(); step();
  endtask

  task automatic test_valid_gate();
    mem_valid = 1'b0; mem_pc = 32'h8000_2000; flags = 7'b0001100;
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL bubble got=%h exp=%h", obs, exp);
    end
    step(); clr(); step();
  endtask

  task automatic test_interrupt();
    mem_valid = 1'b1; mem_pc = 32'h8000_3000;
    status = 32'h0000_0401; cause = 32'h0000_0400;
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_latency got=%h exp=%h", obs, exp);
    end
    step();
    exp = o(32'h1, 32'h8000_3000, 1'b0, 32'h0, 1'b1, VEC); total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_commit got=%h exp=%h", obs, exp);
    end
    step();
    status = 32'h0000_0403;
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_blank got=%h exp=%h", obs, exp);
    end
    step();
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_exl_0 got=%h exp=%h", obs, exp);
    end
    step();
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_exl_1 got=%h exp=%h", obs, exp);
    end
    clr(); step();
    mem_valid = 1'b1; mem_pc = 32'h8000_3100; cause = 32'h0000_0400;
    wb_we = 1'b1; wb_waddr = 5'd12; wb_data = 32'h0000_0401;
    step();
    exp = o(32'h1, 32'h8000_3100, 1'b0, 32'h0, 1'b1, VEC); total++;
    if (obs !== exp) begin
      bad++; $display("FAIL int_bypass got=%h exp=%h", obs, exp);
    end
    step(); clr(); step(); step();
  endtask

  task automatic test_eret();
    mem_valid = 1'b1; mem_pc = 32'h8000_4000; flags = 7'b1000000;
    epc = 32'hDEAD_BEEF;
    wb_we = 1'b1; wb_waddr = 5'd14; wb_data = 32'h1234_5678;
    #1;
    exp = o(32'he, 32'h8000_4000, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL eret_bypass got=%h exp=%h", obs, exp);
    end
    step(); clr(); step();
  endtask

  task automatic test_stall_hold();
    longest_stall = 1'b1;
    mem_valid = 1'b1; mem_pc = 32'hBFC0_0200; flags = 7'b0001000;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = ZERO; total++;
      if (obs !== exp) begin
        bad++; $display("FAIL stall_%0d got=%h exp=%h", i, obs, exp);
      end
      step();
      flags = 7'b0000100; mem_pc = 32'hBFC0_0300;
    end
    longest_stall = 1'b0;
    #1;
    exp = o(32'h9, 32'hBFC0_0200, 1'b0, 32'h0, 1'b1, VEC); total++;
    if (obs !== exp) begin
      bad++; $display("FAIL hold_commit got=%h exp=%h", obs, exp);
    end
    step();
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL hold_blank got=%h exp=%h", obs, exp);
    end
    clr(); step();
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL hold_once got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_reset_in_hold();
    longest_stall = 1'b1;
    mem_valid = 1'b1; mem_pc = 32'hBFC0_0400; flags = 7'b0001000;
    step();
    rst = 1'b1; longest_stall = 1'b0;
    #1;
    exp = ZERO; total++;
    if (obs !== exp) begin
      bad++; $display("FAIL rst_hold got=%h exp=%h", obs, exp);
    end
    step();
    rst = 1'b0; clr();
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = ZERO; total++;
      if (obs !== exp) begin
        bad++; $display("FAIL rst_drop_%0d got=%h exp=%h", i, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_fetch_adel();
    mem_valid = 1'b1; mem_pc = 32'hBFC0_0101; mem_dslot = 1'b1;
    flags = 7'b0100011;
    #1;
    exp = o(32'h4, 32'hBFC0_0101, 1'b1, 32'hBFC0_0101, 1'b1, VEC);
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL fetch_adel got=%h exp=%h", obs, exp);
    end
    step(); clr(); step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr();
    test_reset();
    test_sys();
    test_ld_adel();
    test_valid_gate();
    test_interrupt();
    test_eret();
    test_stall_hold();
    test_reset_in_hold();
    test_fetch_adel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
